icache_miss_alloc: RTL and testbench

ICACHE_MISS_ALLOC -- requirements
Module: icache_miss_alloc

---
 rtl/icache_miss_alloc.sv | 158 +++++++++++++++
 tb/tb_icache_miss_alloc.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_miss_alloc.sv
// Instruction-cache miss allocator: tracks outstanding line fills, merges repeat misses, issues memory reads.
// Latency: alloc handshake is combinational; a new entry is presented as req_vld_o on the following cycle.
// Backpressure: alloc_rdy_o drops when no free entry exists and the address does not merge; PEND entries wait on req_rdy_i.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   alloc_vld_i/alloc_addr_i          miss request from the lookup stage
//   alloc_rdy_o/alloc_id_o/alloc_merge_o  accept, entry id used, merged into an in-flight entry
//   req_vld_o/req_rdy_i/req_id_o/req_addr_o  memory read request channel
//   resp_vld_i/resp_id_i              refill complete for an entry
//   full_o/empty_o/busy_cnt_o         occupancy status, derived from registered state
//   err_o                             sticky: response arrived for an entry not waiting on memory
module icache_miss_alloc #(
    parameter int ENTRY_NUM = 4,
    parameter int ADDR_W    = 40,
    localparam int IDW      = $clog2(ENTRY_NUM)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              alloc_vld_i,
    input  logic [ADDR_W-1:0] alloc_addr_i,
    output logic              alloc_rdy_o,
    output logic [IDW-1:0]    alloc_id_o,
    output logic              alloc_merge_o,
    output logic              req_vld_o,
    input  logic              req_rdy_i,
    output logic [IDW-1:0]    req_id_o,
    output logic [ADDR_W-1:0] req_addr_o,
    input  logic              resp_vld_i,
    input  logic [IDW-1:0]    resp_id_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [IDW:0]      busy_cnt_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_WAIT = 2'd2
    } ent_state_e;

    localparam logic [ENTRY_NUM-1:0] ONE = ENTRY_NUM'(1);

    ent_state_e        state_q [ENTRY_NUM];
    ent_state_e        state_d [ENTRY_NUM];
    logic [ADDR_W-1:0] addr_q  [ENTRY_NUM];
    logic [ADDR_W-1:0] addr_d  [ENTRY_NUM];
    logic              err_q;
    logic              err_d;

    logic [ENTRY_NUM-1:0] idle_vec, pend_vec, match_vec;
    logic [ENTRY_NUM-1:0] free_oh, pend_oh, match_oh;
    logic [ENTRY_NUM-1:0] alloc_oh, issue_oh, resp_oh;
    logic [IDW-1:0]       free_idx, pend_idx, match_idx;
    logic [IDW:0]         busy_cnt;
    logic                 resp_bad;

    function automatic logic [IDW-1:0] oh2bin(input logic [ENTRY_NUM-1:0] oh);
        logic [IDW-1:0] bin;
        bin = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (oh[i]) bin = bin | i[IDW-1:0];
        end
        return bin;
    endfunction

    // Per-entry status vectors, all from registered state only.
    always_comb begin
        idle_vec  = '0;
        pend_vec  = '0;
        match_vec = '0;
        busy_cnt  = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            idle_vec[i]  = (state_q[i] == S_IDLE);
            pend_vec[i]  = (state_q[i] == S_PEND);
            match_vec[i] = (state_q[i] != S_IDLE) && (addr_q[i] == alloc_addr_i);
            busy_cnt     = busy_cnt + {{IDW{1'b0}}, (state_q[i] != S_IDLE)};
        end
    end

    // Isolate the lowest set bit (x & -x), then encode to an index.
    assign free_oh   = idle_vec  & (~idle_vec  + ONE);
    assign pend_oh   = pend_vec  & (~pend_vec  + ONE);
    assign match_oh  = match_vec & (~match_vec + ONE);
    assign free_idx  = oh2bin(free_oh);
    assign pend_idx  = oh2bin(pend_oh);
    assign match_idx = oh2bin(match_oh);

    assign full_o        = ~|idle_vec;
    assign empty_o       = &idle_vec;
    assign busy_cnt_o    = busy_cnt;
    assign alloc_merge_o = alloc_vld_i & (|match_vec);
    assign alloc_rdy_o   = alloc_merge_o | ~full_o;
    assign alloc_id_o    = alloc_merge_o ? match_idx : free_idx;
    assign req_vld_o     = |pend_vec;
    assign req_id_o      = pend_idx;
    assign req_addr_o    = addr_q[pend_idx];
    assign err_o         = err_q;

    // The three events can only hit distinct entries (IDLE, PEND and WAIT
    // respectively), so they are applied independently. A response frees its
    // entry only at the edge; free_oh was computed before it, so that entry
    // cannot be reused in the same cycle.
    always_comb begin
        alloc_oh = (alloc_vld_i & ~alloc_merge_o & ~full_o) ? free_oh : '0;
        issue_oh = req_rdy_i ? pend_oh : '0;
        resp_oh  = resp_vld_i ? (ONE << resp_id_i) : '0;
        resp_bad = resp_vld_i & (state_q[resp_id_i] != S_WAIT);
        err_d    = err_q | resp_bad;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            state_d[i] = state_q[i];
            addr_d[i]  = addr_q[i];
            if (alloc_oh[i]) begin
                state_d[i] = S_PEND;
                addr_d[i]  = alloc_addr_i;
            end
            if (issue_oh[i]) state_d[i] = S_WAIT;
            if (resp_oh[i] && state_q[i] == S_WAIT) state_d[i] = S_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                state_q[i] <= S_IDLE;
                addr_q[i]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                state_q[i] <= state_d[i];
                addr_q[i]  <= addr_d[i];
            end
            err_q <= err_d;
        end
    end

`ifndef SYNTHESIS
    // A stalled request keeps its payload. The only legal change is a switch
    // to a lower index, which happens when a freed lower entry is refilled
    // while a higher one is still stalled.
    logic              stall_q;
    logic [IDW-1:0]    stall_id_q;
    logic [ADDR_W-1:0] stall_addr_q;

    always_ff @(posedge clk_i) begin
        stall_q      <= !rst_i && req_vld_o && !req_rdy_i;
        stall_id_q   <= req_id_o;
        stall_addr_q <= req_addr_o;
        if (!rst_i && stall_q) begin
            assert (req_vld_o && ((req_id_o < stall_id_q) ||
                    (req_id_o == stall_id_q && req_addr_o == stall_addr_q)));
        end
    end
`endif

endmodule

// File: tb/tb_icache_miss_alloc.sv
module tb_icache_miss_alloc;
    localparam int N   = 4;
    localparam int AW  = 40;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           alloc_vld;
    logic [AW-1:0]  alloc_addr;
    logic           alloc_rdy;
    logic [IDW-1:0] alloc_id;
    logic           alloc_merge;
    logic           req_vld;
    logic           req_rdy;
    logic [IDW-1:0] req_id;
    logic [AW-1:0]  req_addr;
    logic           resp_vld;
    logic [IDW-1:0] resp_id;
    logic           full;
    logic           empty;
    logic [IDW:0]   busy_cnt;
    logic           err;

    int errors = 0;
    int checks = 0;

    icache_miss_alloc #(.ENTRY_NUM(N), .ADDR_W(AW)) dut (
        .clk_i(clk), .rst_i(rst),
        .alloc_vld_i(alloc_vld), .alloc_addr_i(alloc_addr),
        .alloc_rdy_o(alloc_rdy), .alloc_id_o(alloc_id), .alloc_merge_o(alloc_merge),
        .req_vld_o(req_vld), .req_rdy_i(req_rdy), .req_id_o(req_id), .req_addr_o(req_addr),
        .resp_vld_i(resp_vld), .resp_id_i(resp_id),
        .full_o(full), .empty_o(empty), .busy_cnt_o(busy_cnt), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_vld  = 1'b0;
        alloc_addr = '0;
        req_rdy    = 1'b0;
        resp_vld   = 1'b0;
        resp_id    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        checks++;
        if ({empty, full, req_vld, err, busy_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_status: got %b want %b", {empty, full, req_vld, err, busy_cnt}, 7'b1000000);
        end
        alloc_vld  = 1'b1;
        alloc_addr = 40'h123;
        #1;
        checks++;
        if ({alloc_rdy, alloc_merge, alloc_id} !== {1'b1, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL reset_alloc_rdy: got %b want %b", {alloc_rdy, alloc_merge, alloc_id}, 4'b1000);
        end
        alloc_vld = 1'b0;
    endtask

    task automatic test_first_alloc();
        do_reset();
        alloc_vld  = 1'b1;
        alloc_addr = 40'h100;
        #2;
        checks++;
        if ({alloc_rdy, alloc_merge, alloc_id} !== {1'b1, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL first_alloc_id: got %b want %b", {alloc_rdy, alloc_merge, alloc_id}, 4'b1000);
        end
        tick();
        alloc_vld = 1'b0;
        #2;
        checks++;
        if ({req_vld, req_id, req_addr, busy_cnt} !== {1'b1, 2'd0, 40'h100, 3'd1}) begin
            errors++;
            $display("FAIL first_req: got vld=%b id=%0d addr=%0h busy=%0d want 1 0 100 1",
                     req_vld, req_id, req_addr, busy_cnt);
        end
    endtask

    task automatic test_fill_and_merge();
        do_reset();
        alloc_vld = 1'b1;
        for (int k = 0; k < N; k++) begin
            alloc_addr = 40'h100 + 40'(k) * 40'h40;
            #2;
            checks++;
            if ({alloc_rdy, alloc_merge, alloc_id} !== {1'b1, 1'b0, 2'(k)}) begin
                errors++;
                $display("FAIL fill_alloc_%0d: got rdy=%b merge=%b id=%0d want 1 0 %0d",
                         k, alloc_rdy, alloc_merge, alloc_id, k);
            end
            tick();
        end
        alloc_vld = 1'b0;
        #2;
        checks++;
        if ({full, busy_cnt} !== {1'b1, 3'd4}) begin
            errors++;
            $display("FAIL fill_full: got full=%b busy=%0d want 1 4", full, busy_cnt);
        end
        alloc_vld  = 1'b1;
        alloc_addr = 40'h200;
        #1;
        checks++;
        if (alloc_rdy !== 1'b0) begin
            errors++;
            $display("FAIL full_reject: got alloc_rdy=%b want 0", alloc_rdy);
        end
        alloc_addr = 40'h140;
        #1;
        checks++;
        if ({alloc_rdy, alloc_merge, alloc_id} !== {1'b1, 1'b1, 2'd1}) begin
            errors++;
            $display("FAIL full_merge: got %b want %b", {alloc_rdy, alloc_merge, alloc_id}, 4'b1101);
        end
        tick();
        alloc_vld = 1'b0;
        #2;
        checks++;
        if ({busy_cnt, req_vld, req_id, req_addr} !== {3'd4, 1'b1, 2'd0, 40'h100}) begin
            errors++;
            $display("FAIL merge_no_change: got busy=%0d vld=%b id=%0d addr=%0h want 4 1 0 100",
                     busy_cnt, req_vld, req_id, req_addr);
        end
    endtask

    task automatic test_resp_realloc();
        do_reset();
        req_rdy   = 1'b1;
        alloc_vld = 1'b1;
        for (int k = 0; k < N; k++) begin
            alloc_addr = 40'h100 + 40'(k) * 40'h40;
            tick();
        end
        alloc_vld = 1'b0;
        tick();
        #2;
        checks++;
        if ({full, req_vld, busy_cnt} !== {1'b1, 1'b0, 3'd4}) begin
            errors++;
            $display("FAIL all_wait: got full=%b req_vld=%b busy=%0d want 1 0 4", full, req_vld, busy_cnt);
        end
        resp_vld   = 1'b1;
        resp_id    = 2'd2;
        alloc_vld  = 1'b1;
        alloc_addr = 40'h200;
        #1;
        checks++;
        if ({alloc_rdy, alloc_merge} !== 2'b00) begin
            errors++;
            $display("FAIL no_same_cycle_reuse: got rdy=%b merge=%b want 0 0", alloc_rdy, alloc_merge);
        end
        tick();
        resp_vld = 1'b0;
        #2;
        checks++;
        if ({full, busy_cnt, alloc_rdy, alloc_merge, alloc_id} !== {1'b0, 3'd3, 1'b1, 1'b0, 2'd2}) begin
            errors++;
            $display("FAIL realloc_freed: got full=%b busy=%0d rdy=%b merge=%b id=%0d want 0 3 1 0 2",
                     full, busy_cnt, alloc_rdy, alloc_merge, alloc_id);
        end
        tick();
        alloc_vld = 1'b0;
        req_rdy   = 1'b0;
        #2;
        checks++;
        if ({req_vld, req_id, req_addr} !== {1'b1, 2'd2, 40'h200}) begin
            errors++;
            $display("FAIL realloc_req: got vld=%b id=%0d addr=%0h want 1 2 200", req_vld, req_id, req_addr);
        end
        // response to entry 1 while 0x140 misses again: still merges; issue of 2 in the same cycle
        resp_vld   = 1'b1;
        resp_id    = 2'd1;
        alloc_vld  = 1'b1;
        alloc_addr = 40'h140;
        req_rdy    = 1'b1;
        #1;
        checks++;
        if ({alloc_rdy, alloc_merge, alloc_id} !== {1'b1, 1'b1, 2'd1}) begin
            errors++;
            $display("FAIL merge_during_resp: got %b want %b", {alloc_rdy, alloc_merge, alloc_id}, 4'b1101);
        end
        tick();
        idle_inputs();
        #2;
        checks++;
        if ({busy_cnt, req_vld, err} !== {3'd3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL concurrent_events: got busy=%0d req_vld=%b err=%b want 3 0 0", busy_cnt, req_vld, err);
        end
    endtask

    task automatic test_issue_order();
        logic [AW-1:0] exp_addr [2];
        logic [6:0]    pat;
        int            ptr;
        int            issued;
        exp_addr[0] = 40'hA00;
        exp_addr[1] = 40'hA40;
        pat    = 7'b0010100;
        ptr    = 0;
        issued = 0;
        do_reset();
        alloc_vld  = 1'b1;
        alloc_addr = 40'hA00;
        tick();
        alloc_addr = 40'hA40;
        tick();
        alloc_vld = 1'b0;
        for (int c = 0; c < 7; c++) begin
            req_rdy = pat[c];
            #2;
            checks++;
            if (ptr < 2) begin
                if ({req_vld, req_id, req_addr} !== {1'b1, 2'(ptr), exp_addr[ptr]}) begin
                    errors++;
                    $display("FAIL issue_cycle_%0d: got vld=%b id=%0d addr=%0h want 1 %0d %0h",
                             c, req_vld, req_id, req_addr, ptr, exp_addr[ptr]);
                end
            end else if (req_vld !== 1'b0) begin
                errors++;
                $display("FAIL issue_cycle_%0d: got req_vld=%b want 0", c, req_vld);
            end
            if (req_vld === 1'b1 && req_rdy) issued++;
            if (req_rdy && ptr < 2) ptr++;
            tick();
        end
        req_rdy = 1'b0;
        checks++;
        if (issued != 2) begin
            errors++;
            $display("FAIL issue_count: got %0d want 2", issued);
        end
    endtask

    task automatic test_err();
        do_reset();
        alloc_vld  = 1'b1;
        alloc_addr = 40'h300;
        tick();
        alloc_vld = 1'b0;
        resp_vld  = 1'b1;
        resp_id   = 2'd3;
        tick();
        resp_vld = 1'b0;
        #2;
        checks++;
        if ({err, busy_cnt, req_vld, req_id} !== {1'b1, 3'd1, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL err_idle_resp: got err=%b busy=%0d vld=%b id=%0d want 1 1 1 0",
                     err, busy_cnt, req_vld, req_id);
        end
        resp_vld = 1'b1;
        resp_id  = 2'd0;
        tick();
        resp_vld = 1'b0;
        #2;
        checks++;
        if ({err, busy_cnt, req_vld} !== {1'b1, 3'd1, 1'b1}) begin
            errors++;
            $display("FAIL err_pend_resp: got err=%b busy=%0d vld=%b want 1 1 1", err, busy_cnt, req_vld);
        end
        repeat (3) tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b want 1", err);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared: got %b want 0", err);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req_rdy   = 1'b1;
        alloc_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            alloc_addr = 40'h400 + 40'(k) * 40'h40;
            tick();
        end
        alloc_vld = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        checks++;
        if ({empty, busy_cnt, req_vld} !== {1'b1, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: got empty=%b busy=%0d vld=%b want 1 0 0", empty, busy_cnt, req_vld);
        end
        resp_vld = 1'b1;
        resp_id  = 2'd1;
        tick();
        idle_inputs();
        #2;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL stale_resp_err: got %b want 1", err);
        end
    endtask

    task automatic test_random();
        bit            m_busy [N];
        bit            m_sent [N];
        logic [AW-1:0] m_addr [N];
        bit            m_err;
        int            wq [$];
        do_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 0;
            m_sent[i] = 0;
            m_addr[i] = '0;
        end
        m_err = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit e_merge, e_free, e_req, e_full, e_rdy;
            int e_mid, e_fid, e_pid, nbusy, e_id;
            alloc_vld  = ($urandom_range(0, 9) < 6);
            alloc_addr = 40'h1000 + 40'($urandom_range(0, 5)) * 40'h40;
            req_rdy    = 1'($urandom_range(0, 1));
            resp_vld   = ($urandom_range(0, 9) < 4);
            wq.delete();
            for (int i = 0; i < N; i++) if (m_busy[i] && m_sent[i]) wq.push_back(i);
            if (wq.size() > 0 && $urandom_range(0, 19) != 0)
                resp_id = 2'(wq[$urandom_range(0, wq.size() - 1)]);
            else
                resp_id = 2'($urandom_range(0, 3));
            #2;
            e_merge = 0; e_free = 0; e_req = 0;
            e_mid = 0; e_fid = 0; e_pid = 0; nbusy = 0;
            for (int i = 0; i < N; i++) begin
                if (m_busy[i]) nbusy++;
                if (!e_merge && m_busy[i] && m_addr[i] == alloc_addr) begin e_merge = 1; e_mid = i; end
                if (!e_free && !m_busy[i]) begin e_free = 1; e_fid = i; end
                if (!e_req && m_busy[i] && !m_sent[i]) begin e_req = 1; e_pid = i; end
            end
            e_merge = e_merge && alloc_vld;
            e_full  = (nbusy == N);
            e_rdy   = e_merge || !e_full;
            e_id    = e_merge ? e_mid : e_fid;
            checks++;
            if ({alloc_rdy, alloc_merge} !== {e_rdy, e_merge}) begin
                errors++;
                $display("FAIL rnd_alloc_hs cyc=%0d: got rdy=%b merge=%b want %b %b",
                         cyc, alloc_rdy, alloc_merge, e_rdy, e_merge);
            end
            if (alloc_vld && e_rdy) begin
                checks++;
                if (alloc_id !== 2'(e_id)) begin
                    errors++;
                    $display("FAIL rnd_alloc_id cyc=%0d: got %0d want %0d", cyc, alloc_id, e_id);
                end
            end
            checks++;
            if ({full, empty, busy_cnt} !== {e_full, nbusy == 0, 3'(nbusy)}) begin
                errors++;
                $display("FAIL rnd_status cyc=%0d: got full=%b empty=%b busy=%0d want busy=%0d",
                         cyc, full, empty, busy_cnt, nbusy);
            end
            checks++;
            if (req_vld !== e_req) begin
                errors++;
                $display("FAIL rnd_req_vld cyc=%0d: got %b want %b", cyc, req_vld, e_req);
            end else if (e_req) begin
                checks++;
                if ({req_id, req_addr} !== {2'(e_pid), m_addr[e_pid]}) begin
                    errors++;
                    $display("FAIL rnd_req_payload cyc=%0d: got id=%0d addr=%0h want %0d %0h",
                             cyc, req_id, req_addr, e_pid, m_addr[e_pid]);
                end
            end
            checks++;
            if (err !== m_err) begin
                errors++;
                $display("FAIL rnd_err cyc=%0d: got %b want %b", cyc, err, m_err);
            end
            // model update, every decision taken from pre-edge state
            if (resp_vld) begin
                if (m_busy[resp_id] && m_sent[resp_id]) m_busy[resp_id] = 0;
                else m_err = 1;
            end
            if (e_req && req_rdy) m_sent[e_pid] = 1;
            if (alloc_vld && !e_merge && !e_full) begin
                m_busy[e_fid] = 1;
                m_sent[e_fid] = 0;
                m_addr[e_fid] = alloc_addr;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_first_alloc();
        test_fill_and_merge();
        test_resp_realloc();
        test_issue_order();
        test_err();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
